// File: rtl/inst_fetcher_pkg.sv
// Shared widths, opcode codes, instruction field ranges and predictor sizing
// for the instruction fetcher and its branch history table.
package inst_fetcher_pkg;

  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int DATA_W    = 32;

  localparam int BHT_SIZE  = 256;
  localparam int BHT_IDX_W = 8;
  localparam int BHT_IDX_LO = 2;
  localparam int BHT_IDX_HI = BHT_IDX_LO + BHT_IDX_W - 1;

  localparam int OPC_HI = 6;
  localparam int OPC_LO = 0;

  localparam logic [OPC_HI:OPC_LO] OP_JAL  = 7'b1101111;
  localparam logic [OPC_HI:OPC_LO] OP_JALR = 7'b1100111;
  localparam logic [OPC_HI:OPC_LO] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_BUF   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              pred;
    logic [ADDR_W-1:0] next_pc;
  } fetch_buf_t;

  function automatic logic signed [ADDR_W-1:0] imm_j(input logic [INST_W-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic signed [ADDR_W-1:0] imm_b(input logic [INST_W-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_predictor.sv
// Branch history table: 2-bit saturating counters with a combinational read
// port (old value on same-index update) and a committed-branch update port.
module inst_fetcher_predictor
  import inst_fetcher_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 upd,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  logic [1:0] cnt_q [BHT_SIZE];

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) cnt_q[i] <= 2'b01;
    end else if (en && upd) begin
      cnt_q[upd_idx] <= sat_step(cnt_q[upd_idx], upd_taken);
    end
  end

  assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: requests one word at a time, buffers it with its
// predicted next PC, hands it to the decoder and handles mispredict redirects.
module inst_fetcher
  import inst_fetcher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_inst,
  input  logic              stall,
  output logic              inst_rdy,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_pred_jump,
  input  logic              rollback,
  input  logic [ADDR_W-1:0] rollback_pc,
  input  logic              br_commit,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              br_taken
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  fetch_buf_t        buf_q;
  fetch_buf_t        buf_d;
  logic              bht_taken;
  logic              unused_br_pc;

  assign unused_br_pc = ^{br_pc[ADDR_W-1:BHT_IDX_HI+1], br_pc[BHT_IDX_LO-1:0]};

  inst_fetcher_predictor predictor (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .rd_idx    (pc_q[BHT_IDX_HI:BHT_IDX_LO]),
    .rd_taken  (bht_taken),
    .upd       (br_commit),
    .upd_idx   (br_pc[BHT_IDX_HI:BHT_IDX_LO]),
    .upd_taken (br_taken)
  );

  // Prediction is resolved as the word arrives so the buffer carries it.
  always_comb begin
    buf_d         = '0;
    buf_d.inst    = mem_inst;
    buf_d.pc      = pc_q;
    buf_d.pred    = 1'b0;
    buf_d.next_pc = pc_q + 32'd4;
    case (mem_inst[OPC_HI:OPC_LO])
      OP_JAL: begin
        buf_d.pred    = 1'b1;
        buf_d.next_pc = pc_q + imm_j(mem_inst);
      end
      OP_BR: begin
        if (bht_taken) begin
          buf_d.pred    = 1'b1;
          buf_d.next_pc = pc_q + imm_b(mem_inst);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      req_pc_q <= '0;
      buf_q    <= '0;
    end else if (rdy) begin
      case (state_q)
        S_FETCH: begin
          // Remember the outstanding address in case a redirect forces a drain.
          req_pc_q <= pc_q;
          if (rollback) begin
            pc_q    <= rollback_pc;
            state_q <= mem_done ? S_FETCH : S_DRAIN;
          end else if (mem_done) begin
            buf_q   <= buf_d;
            state_q <= S_BUF;
          end
        end
        S_BUF: begin
          if (rollback) begin
            pc_q    <= rollback_pc;
            state_q <= S_FETCH;
          end else if (!stall) begin
            pc_q    <= buf_q.next_pc;
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (rollback) pc_q <= rollback_pc;
          if (mem_done) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_en         = !rst && (state_q != S_BUF);
  assign mem_pc         = (state_q == S_DRAIN) ? req_pc_q : pc_q;
  assign inst_rdy       = !rst && rdy && (state_q == S_BUF) && !stall && !rollback;
  assign inst           = buf_q.inst;
  assign inst_pc        = buf_q.pc;
  assign inst_pred_jump = buf_q.pred;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scenario bench for inst_fetcher: scripted memory responses, a scoreboard of
// words expected at the decoder, and explicit next-PC expectations.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        mem_en;
  logic [31:0] mem_pc;
  logic        mem_done;
  logic [31:0] mem_inst;
  logic        stall;
  logic        inst_rdy;
  logic [31:0] inst, inst_pc;
  logic        inst_pred_jump;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        br_commit;
  logic [31:0] br_pc;
  logic        br_taken;

  int nchk  = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        pred;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] JALR = 32'h000080E7;

  inst_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_done(mem_done), .mem_inst(mem_inst),
    .stall(stall), .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
    .inst_pred_jump(inst_pred_jump), .rollback(rollback), .rollback_pc(rollback_pc),
    .br_commit(br_commit), .br_pc(br_pc), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_j(input int imm);
    logic [31:0] u;
    u = imm;
    return {u[20], u[10:1], u[11], u[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] u;
    u = imm;
    return {u[12], u[10:5], 5'd2, 5'd1, 3'b000, u[4:1], u[11], 7'b1100011};
  endfunction

  task automatic wait_req(input logic [31:0] exp_pc);
    int n = 0;
    #1;
    while (!mem_en && n < 20) begin
      @(negedge clk); #1; n++;
    end
    nchk++;
    if (mem_en !== 1'b1) begin
      nfail++; $display("FAIL req_timeout: mem_en=%b after %0d cycles, required 1", mem_en, n);
    end
    nchk++;
    if (mem_pc !== exp_pc) begin
      nfail++; $display("FAIL req_pc: mem_pc=%h, required %h", mem_pc, exp_pc);
    end
  endtask

  task automatic fetch_word(input logic [31:0] pc, input logic [31:0] word, input int lat,
                            input int stall_n, input logic exp_pred, input logic [31:0] exp_next,
                            input bit commit_at_latch);
    exp_t e;
    wait_req(pc);
    repeat (lat) begin
      @(negedge clk); #1;
      nchk++;
      if (mem_en !== 1'b1 || mem_pc !== pc) begin
        nfail++; $display("FAIL req_hold: mem_en=%b mem_pc=%h, required 1 %h", mem_en, mem_pc, pc);
      end
    end
    mem_done = 1'b1; mem_inst = word;
    if (commit_at_latch) begin
      br_commit = 1'b1; br_pc = pc; br_taken = 1'b1;
    end
    sb.push_back('{pc, word, exp_pred});
    #1;
    nchk++;
    if (inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL rdy_in_fetch: inst_rdy=%b, required 0", inst_rdy);
    end
    @(negedge clk);
    mem_done = 1'b0; br_commit = 1'b0; mem_inst = '0;
    for (int s = 0; s < stall_n; s++) begin
      stall = 1'b1; #1;
      nchk++;
      if (inst_rdy !== 1'b0 || mem_en !== 1'b0 || inst !== word) begin
        nfail++;
        $display("FAIL stall_hold: cyc=%0d inst_rdy=%b mem_en=%b inst=%h, required 0 0 %h",
                 s, inst_rdy, mem_en, inst, word);
      end
      @(negedge clk);
    end
    stall = 1'b0; #1;
    nchk++;
    if (inst_rdy !== 1'b1) begin
      nfail++; $display("FAIL handover: pc=%h inst_rdy=%b, required 1", pc, inst_rdy);
    end else if (sb.size() == 0) begin
      nfail++; $display("FAIL sb_empty: inst_rdy=1 with inst=%h, required no presentation", inst);
    end else begin
      e = sb.pop_front();
      nchk++;
      if (inst !== e.word || inst_pc !== e.pc || inst_pred_jump !== e.pred) begin
        nfail++;
        $display("FAIL handover_data: inst=%h pc=%h pred=%b, required %h %h %b",
                 inst, inst_pc, inst_pred_jump, e.word, e.pc, e.pred);
      end
    end
    @(negedge clk); #1;
    nchk++;
    if (inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL one_cycle: inst_rdy=%b after handover, required 0", inst_rdy);
    end
    nchk++;
    if (mem_en !== 1'b1 || mem_pc !== exp_next) begin
      nfail++;
      $display("FAIL next_pc: after pc=%h mem_en=%b mem_pc=%h, required 1 %h",
               pc, mem_en, mem_pc, exp_next);
    end
  endtask

  task automatic commit(input logic [31:0] pc, input logic taken, input int n);
    repeat (n) begin
      br_commit = 1'b1; br_pc = pc; br_taken = taken;
      @(negedge clk);
    end
    br_commit = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; mem_done = 1'b0; mem_inst = '0; stall = 1'b0;
    rollback = 1'b0; rollback_pc = '0; br_commit = 1'b0; br_pc = '0; br_taken = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if (mem_en !== 1'b0 || inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL reset_ctrl: mem_en=%b inst_rdy=%b, required 0 0", mem_en, inst_rdy);
    end
    nchk++;
    if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_pred_jump !== 1'b0) begin
      nfail++; $display("FAIL reset_buf: inst=%h pc=%h pred=%b, required 0", inst, inst_pc, inst_pred_jump);
    end
    rst = 1'b0; #1;
    nchk++;
    if (mem_en !== 1'b1 || mem_pc !== 32'h0) begin
      nfail++; $display("FAIL first_req: mem_en=%b mem_pc=%h, required 1 0", mem_en, mem_pc);
    end
  endtask

  task automatic test_sequential_and_jal;
    fetch_word(32'h0,   ADDI,        0, 0, 1'b0, 32'h4,   1'b0);
    fetch_word(32'h4,   NOP,         2, 0, 1'b0, 32'h8,   1'b0);
    fetch_word(32'h8,   enc_j(32'h100), 1, 0, 1'b1, 32'h108, 1'b0);
    fetch_word(32'h108, enc_j(-232), 0, 0, 1'b1, 32'h20,  1'b0);
  endtask

  task automatic test_branch_predict;
    fetch_word(32'h20, enc_b(-8), 0, 0, 1'b0, 32'h24, 1'b0);
    commit(32'h20, 1'b1, 2);
    fetch_word(32'h24, enc_j(-4), 0, 0, 1'b1, 32'h20, 1'b0);
    fetch_word(32'h20, enc_b(-8), 1, 5, 1'b1, 32'h18, 1'b0);
    commit(32'h20, 1'b1, 3);
    commit(32'h20, 1'b0, 1);
    fetch_word(32'h18, enc_j(8),  0, 0, 1'b1, 32'h20, 1'b0);
    fetch_word(32'h20, enc_b(-8), 0, 0, 1'b1, 32'h18, 1'b0);
    commit(32'h20, 1'b0, 1);
    fetch_word(32'h18, enc_j(8),  0, 0, 1'b1, 32'h20, 1'b0);
    // Update lands on the same index in the latch cycle: old counter decides.
    fetch_word(32'h20, enc_b(-8), 0, 0, 1'b0, 32'h24, 1'b1);
    fetch_word(32'h24, enc_j(-4), 0, 0, 1'b1, 32'h20, 1'b0);
    fetch_word(32'h20, enc_b(-8), 0, 0, 1'b1, 32'h18, 1'b0);
    fetch_word(32'h18, JALR,      0, 0, 1'b0, 32'h1C, 1'b0);
  endtask

  task automatic test_rollback_fetch;
    wait_req(32'h1C);
    rollback = 1'b1; rollback_pc = 32'h400; #1;
    nchk++;
    if (inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL rb_fetch_rdy: inst_rdy=%b, required 0", inst_rdy);
    end
    @(negedge clk);
    rollback = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (mem_en !== 1'b1 || mem_pc !== 32'h1C || inst_rdy !== 1'b0) begin
        nfail++;
        $display("FAIL drain_hold: cyc=%0d mem_en=%b mem_pc=%h inst_rdy=%b, required 1 0000001c 0",
                 i, mem_en, mem_pc, inst_rdy);
      end
      if (i == 2) begin
        mem_done = 1'b1; mem_inst = enc_j(64);
      end
      @(negedge clk);
    end
    mem_done = 1'b0; mem_inst = '0; #1;
    nchk++;
    if (inst_rdy !== 1'b0 || mem_en !== 1'b1 || mem_pc !== 32'h400) begin
      nfail++;
      $display("FAIL drain_exit: inst_rdy=%b mem_en=%b mem_pc=%h, required 0 1 00000400",
               inst_rdy, mem_en, mem_pc);
    end
    fetch_word(32'h400, ADDI, 1, 0, 1'b0, 32'h404, 1'b0);
  endtask

  task automatic test_rollback_done_and_rdy;
    wait_req(32'h404);
    mem_done = 1'b1; mem_inst = enc_j(64); rollback = 1'b1; rollback_pc = 32'h800; #1;
    nchk++;
    if (inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL rb_done_rdy: inst_rdy=%b, required 0", inst_rdy);
    end
    @(negedge clk);
    mem_done = 1'b0; mem_inst = '0; rollback = 1'b0; #1;
    nchk++;
    if (inst_rdy !== 1'b0 || mem_en !== 1'b1 || mem_pc !== 32'h800) begin
      nfail++;
      $display("FAIL rb_done_redirect: inst_rdy=%b mem_en=%b mem_pc=%h, required 0 1 00000800",
               inst_rdy, mem_en, mem_pc);
    end
    // Global enable low: memory return, redirect and branch commits all ignored.
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      br_commit = 1'b1; br_pc = 32'h20; br_taken = 1'b0;
      mem_done  = (i == 1); mem_inst = ADDI;
      rollback  = (i == 2); rollback_pc = 32'h900;
      #1;
      nchk++;
      if (inst_rdy !== 1'b0 || mem_pc !== 32'h800) begin
        nfail++;
        $display("FAIL rdy_freeze: cyc=%0d inst_rdy=%b mem_pc=%h, required 0 00000800",
                 i, inst_rdy, mem_pc);
      end
      @(negedge clk);
    end
    rdy = 1'b1; br_commit = 1'b0; mem_done = 1'b0; mem_inst = '0; rollback = 1'b0; #1;
    nchk++;
    if (mem_en !== 1'b1 || mem_pc !== 32'h800) begin
      nfail++; $display("FAIL rdy_resume: mem_en=%b mem_pc=%h, required 1 00000800", mem_en, mem_pc);
    end
    fetch_word(32'h800, enc_j(-2016), 0, 0, 1'b1, 32'h20, 1'b0);
    fetch_word(32'h20,  enc_b(-8),    0, 0, 1'b1, 32'h18, 1'b0);
  endtask

  task automatic test_rollback_buf;
    wait_req(32'h18);
    mem_done = 1'b1; mem_inst = ADDI;
    @(negedge clk);
    mem_done = 1'b0; mem_inst = '0;
    rollback = 1'b1; rollback_pc = 32'h40; #1;
    nchk++;
    if (inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL rb_buf_rdy: inst_rdy=%b, required 0", inst_rdy);
    end
    @(negedge clk);
    rollback = 1'b0; #1;
    nchk++;
    if (inst_rdy !== 1'b0 || mem_en !== 1'b1 || mem_pc !== 32'h40) begin
      nfail++;
      $display("FAIL rb_buf_redirect: inst_rdy=%b mem_en=%b mem_pc=%h, required 0 1 00000040",
               inst_rdy, mem_en, mem_pc);
    end
  endtask

  task automatic test_reset_mid_request;
    rst = 1'b1;
    @(negedge clk); #1;
    nchk++;
    if (mem_en !== 1'b0 || inst_rdy !== 1'b0) begin
      nfail++; $display("FAIL mid_reset: mem_en=%b inst_rdy=%b, required 0 0", mem_en, inst_rdy);
    end
    rst = 1'b0; #1;
    nchk++;
    if (mem_en !== 1'b1 || mem_pc !== 32'h0) begin
      nfail++; $display("FAIL mid_reset_req: mem_en=%b mem_pc=%h, required 1 0", mem_en, mem_pc);
    end
    fetch_word(32'h0,  enc_j(32),  0, 0, 1'b1, 32'h20, 1'b0);
    fetch_word(32'h20, enc_b(-8),  0, 0, 1'b0, 32'h24, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sequential_and_jal();
    test_branch_predict();
    test_rollback_fetch();
    test_rollback_done_and_rdy();
    test_rollback_buf();
    test_reset_mid_request();
    nchk++;
    if (sb.size() != 0) begin
      nfail++; $display("FAIL sb_leftover: %0d words never presented, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 Port rdy input 1: global enable; when low, all state and registered outputs SHALL hold.
REQ-003 Port mem_en output 1: instruction-word request to the memory controller.
REQ-004 Port mem_pc output 32: byte address of the requested word.
REQ-005 Port mem_done input 1: one-cycle pulse that returns the requested word.
REQ-006 Port mem_inst input 32: returned instruction word, valid with mem_done.
REQ-007 Port stall input 1: downstream RS, LSB or ROB full; no instruction may be handed over.
REQ-008 Port inst_rdy output 1: instruction presented to the decoder this cycle.
REQ-009 Port inst output 32: presented instruction.
REQ-010 Port inst_pc output 32: PC of the presented instruction.
REQ-011 Port inst_pred_jump output 1: predicted-taken flag of the presented instruction.
REQ-012 Port rollback input 1: mispredict flush request.
REQ-013 Port rollback_pc input 32: redirect target, valid with rollback.
REQ-014 Port br_commit input 1: committed conditional branch, used for predictor update.
REQ-015 Port br_pc input 32: PC of the committed branch.
REQ-016 Port br_taken input 1: actual outcome of the committed branch.

Function
REQ-017 The state machine SHALL have three states: FETCH, BUF and DRAIN.
REQ-018 In FETCH the block SHALL drive mem_en=1 and mem_pc=pc; on mem_done it SHALL latch mem_inst into the buffer and go to BUF.
REQ-019 In BUF the block SHALL drive inst_rdy = !stall && !rollback (combinational), with inst, inst_pc and inst_pred_jump taken from the buffer.
REQ-020 In BUF with inst_rdy=1 (handover), the block SHALL set pc to the predicted next PC and go to FETCH, so the next request issues the following cycle; with stall=1 it SHALL stay in BUF with the buffer unchanged.
REQ-021 Predicted next PC for opcode JAL SHALL be taken, target pc + J-immediate.
REQ-022 Predicted next PC for opcode BR SHALL be taken iff BHT[pc[9:2]][1]=1, target pc + B-immediate; otherwise pc+4.
REQ-023 Predicted next PC for JALR and all other opcodes SHALL be pc+4, not taken.
REQ-024 All PC arithmetic SHALL be 32-bit with sign-extended immediates and wrap modulo 2^32.
REQ-025 The prediction SHALL be computed when the word is latched and stored with the buffer.
REQ-026 The BHT SHALL have 256 two-bit saturating counters, indexed by pc[9:2].
REQ-027 On br_commit, BHT[br_pc[9:2]] SHALL increment if br_taken and decrement otherwise, saturating at 11 and 00.
REQ-028 A BHT read and update to the same index in the same cycle SHALL read the old value.
REQ-029 Rollback in BUF, or in FETCH coincident with mem_done, SHALL set pc=rollback_pc, go to FETCH, discard the buffer and keep inst_rdy=0 that cycle.
REQ-030 Rollback in FETCH without mem_done SHALL set pc=rollback_pc and go to DRAIN.
REQ-031 In DRAIN the block SHALL hold mem_en=1 with the old mem_pc until mem_done, discard the returned word, then go to FETCH.
REQ-032 Rollback arriving in DRAIN SHALL update pc only.
REQ-033 rollback SHALL take priority over handover and over mem_done latching.
REQ-034 br_commit SHALL be applied regardless of rollback and state.
REQ-035 When rdy=0, no state, pc or BHT change SHALL occur, mem_done SHALL be ignored, and inst_rdy SHALL be 0.

Reset
REQ-036 While rst=1, the block SHALL hold pc=0, state=FETCH, mem_en=0, inst_rdy=0 and the buffer at 0.
REQ-037 While rst=1, all BHT counters SHALL reset to 01 (weakly not-taken).
REQ-038 The first request SHALL issue in the first cycle after rst deasserts with rdy=1.
REQ-039 Reset mid-request SHALL abandon the request; the memory controller is reset by the same rst.

Structure
REQ-040 Opcode codes, instruction field ranges, ADDR/INST/DATA widths and BHT size/index width SHALL live in the shared macros header.
REQ-041 The BHT (counter array, read port and saturating update) SHALL be one sub-module, predictor; FSM, buffer and next-PC logic SHALL stay in inst_fetcher.

Verification
REQ-042 Scenario: reset, then mem_done with ADDI at pc 0 and stall=0 -> inst_rdy=1 for one cycle with inst_pc=0, inst_pred_jump=0; next mem_pc=0x4.
REQ-043 Scenario: JAL imm=+0x100 at pc 0x8 -> inst_pred_jump=1 and next mem_pc=0x108.
REQ-044 Scenario: BEQ imm=-8 at 0x20, then 2x br_commit(0x20, taken) and refetch -> first pass not taken (next 0x24); after the updates taken (next 0x18); 3 further taken commits leave the counter saturated at 11.
REQ-045 Scenario: stall=1 for 5 cycles in BUF -> inst_rdy=0 and buffer stable throughout; handover in the first cycle stall=0; no mem_en during the stall.
REQ-046 Scenario: rollback to 0x400 while FETCH with the memory delayed 3 cycles -> DRAIN; the word returned from the old mem_pc is never presented; the next request is mem_pc=0x400.
REQ-047 Scenario: rollback coincident with mem_done, and rdy=0 pulses mid-fetch -> no instruction presented and mem_pc=rollback_pc next cycle; rdy=0 freezes pc, state and BHT.
